// File: rtl/rob_ctrl_if.sv
// Issue/CDB/commit/status bundle between the issue stage and the reorder-buffer controller.
// No latency of its own; it carries wires only.
// No backpressure of its own; the grant is returned combinationally on alloc_gnt.
interface rob_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic          alloc_req;
    logic [3:0]    alloc_func;
    logic [3:0]    alloc_rd;
    logic          alloc_gnt;
    logic [AW-1:0] alloc_idx;
    logic          add_release;
    logic          mul_release;
    logic          cdb_valid;
    logic [AW-1:0] cdb_idx;
    logic [DW-1:0] cdb_data;
    logic          commit_valid;
    logic [AW-1:0] commit_idx;
    logic [3:0]    commit_rd;
    logic [DW-1:0] commit_data;
    logic          flush;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [1:0]    add_busy;
    logic [1:0]    mul_busy;

    // Controller side
    modport slave (
        input  alloc_req, alloc_func, alloc_rd, add_release, mul_release,
               cdb_valid, cdb_idx, cdb_data, flush,
        output alloc_gnt, alloc_idx, commit_valid, commit_idx, commit_rd,
               commit_data, full, empty, count, add_busy, mul_busy
    );

    // Issue stage / execution side
    modport master (
        output alloc_req, alloc_func, alloc_rd, add_release, mul_release,
               cdb_valid, cdb_idx, cdb_data, flush,
        input  alloc_gnt, alloc_idx, commit_valid, commit_idx, commit_rd,
               commit_data, full, empty, count, add_busy, mul_busy
    );
endinterface

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocation, CDB completion, in-order single retirement.
// Latency: grant is combinational; commit is registered one edge after the head entry is seen done.
// Backpressure: alloc_gnt is withheld when the ROB is full, the class RS is full, the opcode is illegal, or on flush/reset.
module rob_ctrl #(
    parameter int DEPTH    = 8,
    parameter int DW       = 16,
    parameter int RS_SLOTS = 3
) (
    input  logic  clk1,
    input  logic  rst_n,
    rob_ctrl_if.slave io_bus
);
    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    LP_DEPTH = (AW+1)'(DEPTH);
    localparam logic [1:0]     LP_SLOTS = 2'(RS_SLOTS);

    // Per-entry state
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_done;
    logic [3:0]       r_func [DEPTH];
    logic [3:0]       r_rd   [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];

    // Pointers, occupancy and reservation-station accounting
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [AW:0]      r_count;
    logic [1:0]       r_add_busy;
    logic [1:0]       r_mul_busy;

    // Registered retirement port
    logic             r_commit_valid;
    logic [AW-1:0]    r_commit_idx;
    logic [3:0]       r_commit_rd;
    logic [DW-1:0]    r_commit_data;

    logic w_full;
    logic w_empty;
    logic w_is_add;
    logic w_is_mul;
    logic w_class_room;
    logic w_gnt;
    logic w_commit;
    logic w_cdb_hit;
    logic w_add_inc;
    logic w_add_dec;
    logic w_mul_inc;
    logic w_mul_dec;

    // Grant and retirement decisions from current-cycle state only
    always_comb begin
        w_full       = (r_count == LP_DEPTH);
        w_empty      = (r_count == '0);
        w_is_add     = (io_bus.alloc_func[3:1] == 3'b000);
        w_is_mul     = (io_bus.alloc_func[3:1] == 3'b001);
        w_class_room = (w_is_add && (r_add_busy < LP_SLOTS)) ||
                       (w_is_mul && (r_mul_busy < LP_SLOTS));
        w_gnt        = rst_n && io_bus.alloc_req && !w_full && !io_bus.flush && w_class_room;
        // Only legal opcodes are ever written, so the opcode test just guards a corrupted entry.
        w_commit     = r_vld[r_head] && r_done[r_head] && (r_func[r_head] < 4'd4);
        w_cdb_hit    = io_bus.cdb_valid && r_vld[io_bus.cdb_idx];
        w_add_inc    = w_gnt && w_is_add;
        w_mul_inc    = w_gnt && w_is_mul;
        w_add_dec    = io_bus.add_release && (r_add_busy != 2'd0);
        w_mul_dec    = io_bus.mul_release && (r_mul_busy != 2'd0);
    end

    // Entry array and head/tail pointers: allocate at tail, complete from CDB, retire at head
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_func[i] <= '0;
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
            r_vld  <= '0;
            r_done <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else if (io_bus.flush) begin
            r_vld  <= '0;
            r_done <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_cdb_hit) begin
                r_done[io_bus.cdb_idx] <= 1'b1;
                r_data[io_bus.cdb_idx] <= io_bus.cdb_data;
            end
            // Head and tail can only coincide when empty (no commit) or full (no grant).
            if (w_commit) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_gnt) begin
                r_vld[r_tail]  <= 1'b1;
                r_done[r_tail] <= 1'b0;
                r_func[r_tail] <= io_bus.alloc_func;
                r_rd[r_tail]   <= io_bus.alloc_rd;
                r_tail         <= r_tail + 1'b1;
            end
        end
    end

    // Retirement output register: one entry per cycle, captured from the head before it is freed
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_commit_valid <= 1'b0;
            r_commit_idx   <= '0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
        end else if (io_bus.flush) begin
            r_commit_valid <= 1'b0;
        end else begin
            r_commit_valid <= w_commit;
            if (w_commit) begin
                r_commit_idx  <= r_head;
                r_commit_rd   <= r_rd[r_head];
                r_commit_data <= r_data[r_head];
            end
        end
    end

    // Occupancy and per-class reservation-station counters
    always_ff @(posedge clk1) begin
        if (!rst_n || io_bus.flush) begin
            r_count    <= '0;
            r_add_busy <= '0;
            r_mul_busy <= '0;
        end else begin
            if (w_gnt && !w_commit) begin
                r_count <= r_count + 1'b1;
            end else if (!w_gnt && w_commit) begin
                r_count <= r_count - 1'b1;
            end
            if (w_add_inc && !w_add_dec) begin
                r_add_busy <= r_add_busy + 2'd1;
            end else if (!w_add_inc && w_add_dec) begin
                r_add_busy <= r_add_busy - 2'd1;
            end
            if (w_mul_inc && !w_mul_dec) begin
                r_mul_busy <= r_mul_busy + 2'd1;
            end else if (!w_mul_inc && w_mul_dec) begin
                r_mul_busy <= r_mul_busy - 2'd1;
            end
        end
    end

    assign io_bus.alloc_gnt    = w_gnt;
    assign io_bus.alloc_idx    = r_tail;
    assign io_bus.commit_valid = r_commit_valid;
    assign io_bus.commit_idx   = r_commit_idx;
    assign io_bus.commit_rd    = r_commit_rd;
    assign io_bus.commit_data  = r_commit_data;
    assign io_bus.full         = w_full;
    assign io_bus.empty        = w_empty;
    assign io_bus.count        = r_count;
    assign io_bus.add_busy     = r_add_busy;
    assign io_bus.mul_busy     = r_mul_busy;

endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8: reorder-buffer entries; power of two.
REQ-002 SHALL have parameter DW, default 16: result data width.
REQ-003 SHALL have parameter RS_SLOTS, default 3: reservation-station slots per unit class (add, mul).
REQ-004 SHALL have port clk1  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1: reset, synchronous, active-low.
REQ-006 SHALL have port alloc_req  in  1: issue stage requests a ROB entry.
REQ-007 SHALL have port alloc_func  in  4: opcode; 0000/0001 add class, 0010/0011 mul class.
REQ-008 SHALL have port alloc_rd  in  4: destination register.
REQ-009 SHALL have port alloc_gnt  out  1: combinational grant, same cycle as alloc_req.
REQ-010 SHALL have port alloc_idx  out  log2(DEPTH): tail index given to the granted instruction.
REQ-011 SHALL have port add_release, mul_release  in  1 each: reservation-station slot of that class freed.
REQ-012 SHALL have port cdb_valid  in  1; cdb_idx  in  log2(DEPTH); cdb_data  in  DW: result broadcast.
REQ-013 SHALL have port commit_valid  out  1; commit_idx  out  log2(DEPTH); commit_rd  out  4; commit_data  out  DW: registered in-order retirement.
REQ-014 SHALL have port flush  in  1: synchronous squash of all in-flight state.
REQ-015 SHALL have port full, empty  out  1 each; count  out  log2(DEPTH)+1: occupancy.
REQ-016 SHALL have port add_busy, mul_busy  out  2 each: occupied reservation-station slots per class.

Function
REQ-017 SHALL hold per entry: valid, done, func, rd, data; plus head, tail pointers and count.
REQ-018 SHALL drive alloc_gnt = alloc_req & !full & !flush & legal func & (class busy < RS_SLOTS); illegal func (0100-1111) never granted.
REQ-019 SHALL drive alloc_idx = tail at all times, independent of alloc_req.
REQ-020 On grant, at the edge: entry[tail] <= {valid=1, done=0, func, rd}; tail += 1 mod DEPTH; class busy += 1.
REQ-021 SHALL evaluate full from current-cycle count; a commit in the same cycle does not make room for a grant when full.
REQ-022 On cdb_valid with entry[cdb_idx].valid=1: done <= 1, data <= cdb_data; cdb to an invalid entry is ignored.
REQ-023 When entry[head] valid and done, at the edge: commit_valid <= 1, commit_idx <= head, commit_rd/commit_data <= entry fields; entry valid <= 0; head += 1 mod DEPTH; otherwise commit_valid <= 0.
REQ-024 A CDB write to the head entry commits no earlier than the cycle after the write (commit_valid rises 2 edges after cdb_valid).
REQ-025 SHALL retire at most one entry per cycle, strictly in allocation order.
REQ-026 count SHALL be +1 on grant only, -1 on commit only, unchanged on simultaneous grant and commit.
REQ-027 full = (count == DEPTH); empty = (count == 0); pointers wrap DEPTH-1 -> 0.
REQ-028 Busy counter: +1 on grant of class, -1 on release, unchanged when both; release at 0 ignored; never exceeds RS_SLOTS.
REQ-029 flush at the edge SHALL clear all valid/done, head=tail=0, count=0, busy counters=0, commit_valid=0; flush overrides same-cycle grant, cdb and commit.

Reset
REQ-030 With rst_n=0 at the edge: all state as after flush, plus entry data, commit_idx, commit_rd, commit_data = 0; empty=1, full=0.
REQ-031 Reset mid-operation SHALL discard all in-flight entries; no commit_valid in the cycle following reset.
REQ-032 alloc_gnt SHALL be 0 whenever rst_n=0.

Verification
REQ-033 Issue add(rd=3) idx0, mul(rd=5) idx1; cdb idx1 data=0x00AA, then cdb idx0 data=0x0055 -> commits idx0 rd=3 0x0055, then idx1 rd=5 0x00AA, in order.
REQ-034 Eight allocs with add/mul releases interleaved -> full=1, count=8, ninth alloc_gnt=0; commit one plus same-cycle alloc -> no grant; next cycle grant at idx0 (wrap).
REQ-035 Three add allocs, no release -> fourth add alloc_gnt=0, mul alloc still granted; add_release -> add_busy=2, add granted next cycle.
REQ-036 Allocate 4, cdb two, assert flush with alloc_req -> no grant, count=0, empty=1, busy=0, commit_valid=0 next cycle.
REQ-037 alloc_func=0110 -> alloc_gnt=0, count unchanged; cdb_valid to empty idx5 -> no commit ever.
REQ-038 rst_n=0 one cycle with 3 done entries pending -> commit_valid stays 0, count=0 after reset.
